uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between NUM_REQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional WAIT_BUSY watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  IDLE      | waiting for any req while the UART is not busy
//  ISSUE     | one-cycle grant + uart_enable for the latched winner
//  WAIT_BUSY | waiting for the UART to acknowledge by raising busy
//  WAIT_DONE | waiting for the UART frame to finish (busy low)
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          uart_enable,
    output logic [DATA_WIDTH-1:0]         uart_data,
    input  logic                          uart_busy,
    output logic [ID_W-1:0]               active_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic [ID_W-1:0]       next_id;
    logic [NUM_REQ-1:0]    grant_nxt;
    logic                  enable_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [ID_W-1:0]       id_nxt;
    logic                  timeout_hit;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin : p_scan
        int              idx;
        logic [ID_W-1:0] idx_w;
        idx    = 0;
        idx_w  = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && req[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    assign next_id = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = '0;
        enable_nxt = 1'b0;
        data_nxt   = uart_data;
        id_nxt     = active_id;
        case (state)
            IDLE: begin
                if (found && !uart_busy) begin
                    state_nxt         = ISSUE;
                    grant_nxt[winner] = 1'b1;
                    enable_nxt        = 1'b1;
                    data_nxt          = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    id_nxt            = winner;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_id;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_id;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant       <= '0;
            uart_enable <= 1'b0;
            uart_data   <= '0;
            active_id   <= '0;
            arb_busy    <= 1'b0;
        end else begin
            grant       <= grant_nxt;
            uart_enable <= enable_nxt;
            uart_data   <= data_nxt;
            active_id   <= id_nxt;
            arb_busy    <= (state_nxt != IDLE);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmr;

    // Down-counter reloads whenever outside WAIT_BUSY, so every entry starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= '0;
        end else if (state != WAIT_BUSY) begin
            tmr <= TW'(TIMEOUT_CYCLES - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT_BUSY) && !uart_busy && (tmr == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple busy-counter UART model.
// Watchdog scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DW       = 8;
    localparam int BUSY_LEN = 10;

    logic                  clk;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    grant;
    logic                  uart_enable;
    logic [DW-1:0]         uart_data;
    logic                  uart_busy;
    logic [1:0]            active_id;
    logic                  arb_busy;
    logic                  timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .uart_enable(uart_enable),
        .uart_data  (uart_data),
        .uart_busy  (uart_busy),
        .active_id  (active_id),
        .arb_busy   (arb_busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy for BUSY_LEN cycles after each accepted enable.
    int      busy_cnt  = 0;
    bit      uart_mute = 1'b0;
    logic [DW-1:0] rx_byte = '0;
    always @(posedge clk) begin
        if (uart_enable && !uart_mute) begin
            busy_cnt <= BUSY_LEN;
            rx_byte  <= uart_data;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign uart_busy = (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Invariants sampled at every issue.
    always @(negedge clk) begin
        if (uart_enable) begin
            chk("mon_no_busy_at_enable", {31'd0, uart_busy}, 32'd0);
            chk("mon_grant_onehot", {31'd0, $onehot(grant)}, 32'd1);
        end
    end

    logic [DW-1:0] bytes [NUM_REQ] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic load_bytes();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = bytes[i];
    endtask

    // Returns at the negedge where uart_enable is seen; gap = cycles from busy fall.
    task automatic wait_enable(input int max, output bit ok, output int gap);
        int lowrun;
        lowrun = 0;
        ok     = 1'b0;
        gap    = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (uart_busy) lowrun = 0;
            else lowrun++;
            if (uart_enable) begin
                ok  = 1'b1;
                gap = lowrun - 1;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!arb_busy && !uart_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int gap;
        int n;
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_enable", {31'd0, uart_enable}, 32'd0);
        chk("rst_data", {24'd0, uart_data}, 32'd0);
        chk("rst_id", {30'd0, active_id}, 32'd0);
        chk("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single source: grant one cycle after req.
        req_data[2*DW +: DW] = 8'hA5;
        req = 4'b0100;
        @(negedge clk);
        chk("t1_grant", {28'd0, grant}, 32'h4);
        chk("t1_enable", {31'd0, uart_enable}, 32'd1);
        chk("t1_data", {24'd0, uart_data}, 32'hA5);
        chk("t1_id", {30'd0, active_id}, 32'd2);
        chk("t1_arb_busy", {31'd0, arb_busy}, 32'd1);
        req = '0;
        @(negedge clk);
        chk("t1_grant_pulse", {28'd0, grant}, 32'd0);
        chk("t1_enable_pulse", {31'd0, uart_enable}, 32'd0);
        wait_idle("t1_idle", 50);
        chk("t1_rx", {24'd0, rx_byte}, 32'hA5);
        chk("t1_data_held", {24'd0, uart_data}, 32'hA5);

        // All four requesting from reset: strict rotation 0,1,2,3,0.
        do_reset();
        load_bytes();
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_enable(100, ok, gap);
            chk("t2_seen", {31'd0, ok}, 32'd1);
            chk("t2_id", {30'd0, active_id}, k % NUM_REQ);
            chk("t2_data", {24'd0, uart_data}, {24'd0, bytes[k % NUM_REQ]});
            if (k > 0) chk("t2_gap", gap, 32'd2);
            if (k == 4) req = '0;
        end
        wait_idle("t2_idle", 50);

        // req[1] dropped in WAIT_DONE: its frame completes, next goes to source 3.
        req = 4'b1010;
        wait_enable(50, ok, gap);
        chk("t3_seen1", {31'd0, ok}, 32'd1);
        chk("t3_id1", {30'd0, active_id}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_busy", {31'd0, uart_busy}, 32'd1);
        req = 4'b1000;
        wait_enable(50, ok, gap);
        chk("t3_seen3", {31'd0, ok}, 32'd1);
        chk("t3_id3", {30'd0, active_id}, 32'd3);
        chk("t3_data3", {24'd0, uart_data}, 32'h44);
        chk("t3_gap", gap, 32'd2);
        req = '0;
        wait_idle("t3_idle", 50);

        // Reset mid-frame while the UART is still busy.
        req = 4'b0001;
        wait_enable(50, ok, gap);
        chk("t4_seen", {31'd0, ok}, 32'd1);
        chk("t4_id", {30'd0, active_id}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t4_busy_pre", {31'd0, uart_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_grant", {28'd0, grant}, 32'd0);
        chk("t4_rst_enable", {31'd0, uart_enable}, 32'd0);
        chk("t4_rst_data", {24'd0, uart_data}, 32'd0);
        chk("t4_rst_id", {30'd0, active_id}, 32'd0);
        chk("t4_rst_arb_busy", {31'd0, arb_busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_enable(50, ok, gap);
        chk("t4_seen_after", {31'd0, ok}, 32'd1);
        chk("t4_gap", gap, 32'd1);
        chk("t4_grant", {28'd0, grant}, 32'h1);
        chk("t4_data", {24'd0, uart_data}, 32'h11);
        req = '0;
        wait_idle("t4_idle", 50);

`ifdef UART_ARB_TIMEOUT_EN
        // UART never answers: watchdog fires after 64 cycles in WAIT_BUSY.
        uart_mute = 1'b1;
        req = 4'b0010;
        wait_enable(50, ok, gap);
        chk("t5_seen", {31'd0, ok}, 32'd1);
        chk("t5_id", {30'd0, active_id}, 32'd1);
        req = 4'b0110;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (timeout_err) break;
        end
        chk("t5_cycles", n, 32'd65);
        chk("t5_err", {31'd0, timeout_err}, 32'd1);
        chk("t5_idle", {31'd0, arb_busy}, 32'd0);
        uart_mute = 1'b0;
        wait_enable(50, ok, gap);
        chk("t5_next_seen", {31'd0, ok}, 32'd1);
        chk("t5_next_id", {30'd0, active_id}, 32'd2);
        req = '0;
        wait_idle("t5_idle_end", 50);
        chk("t5_sticky", {31'd0, timeout_err}, 32'd1);
`else
        chk("t5_err_tied", {31'd0, timeout_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
